// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

  localparam int MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/arb_lat_counter.sv
// Access latency counter: loads MEM_LAT-1 on issue, counts down to zero, flags done at zero.
module arb_lat_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (DM over IF) arbiter in front of a single-ported memory with fixed read latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_f,
  output logic          stall_m
);

  arb_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          rst_hold_q, rst_hold_d;
  logic          lat_done;
  logic          issue;
  logic          complete;

  // rst_hold_q keeps the memory port quiet for the first cycle after reset releases
  always_comb begin
    issue    = (state_q == IDLE) && !reset && !rst_hold_q && (dm_req || if_req);
    complete = (state_q != IDLE) && lat_done && !reset;
  end

  always_comb begin
    mem_en    = issue;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue) begin
      if (dm_req) begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end else begin
        mem_addr  = if_addr;
      end
    end else if (!reset && (state_q != IDLE)) begin
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end

    dm_ready = complete && (state_q == BUSY_DM);
    // a fetch whose address moved or whose request dropped is silently discarded
    if_ready = complete && (state_q == BUSY_IF) && if_req && (if_addr == addr_q);
    dm_rdata = (dm_ready && !we_q) ? mem_rdata : '0;
    if_rdata = if_ready ? mem_rdata : '0;
    stall_f  = if_req & ~if_ready;
    stall_m  = dm_req & ~dm_ready;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rst_hold_d = 1'b0;
    if (issue) begin
      state_d = dm_req ? BUSY_DM : BUSY_IF;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      we_d    = mem_we;
    end else if (complete) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rst_hold_q <= rst_hold_d;
    end
  end

  arb_lat_counter #(
    .MEM_LAT(MEM_LAT)
  ) u_lat (
    .clk  (clk),
    .reset(reset),
    .load (issue),
    .done (lat_done)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed latency scenarios plus random traffic against a cycle-numbered model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          reset     [2];
  logic          if_req    [2];
  logic [AW-1:0] if_addr   [2];
  logic [DW-1:0] if_rdata  [2];
  logic          if_ready  [2];
  logic          dm_req    [2];
  logic          dm_we     [2];
  logic [AW-1:0] dm_addr   [2];
  logic [DW-1:0] dm_wdata  [2];
  logic [DW-1:0] dm_rdata  [2];
  logic          dm_ready  [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          stall_f   [2];
  logic          stall_m   [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: an access issued in cycle T completes in cycle T+lat
  bit          m_busy    [2] = '{1'b0, 1'b0};
  bit          m_blk     [2] = '{1'b1, 1'b1};
  bit          m_dm      [2];
  bit          m_we      [2];
  logic [31:0] m_a       [2];
  logic [31:0] m_w       [2];
  int          m_done_at [2];
  bit          rdy_prev  [2] = '{1'b0, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.MEM_LAT(2), .AW(AW), .DW(DW)) u_dut2 (
    .clk(clk), .reset(reset[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ready(if_ready[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_rdata(dm_rdata[0]), .dm_ready(dm_ready[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .stall_f(stall_f[0]), .stall_m(stall_m[0])
  );

  mem_arbiter #(.MEM_LAT(1), .AW(AW), .DW(DW)) u_dut1 (
    .clk(clk), .reset(reset[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ready(if_ready[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_rdata(dm_rdata[1]), .dm_ready(dm_ready[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .stall_f(stall_f[1]), .stall_m(stall_m[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic model_step(input int k);
    bit          e_en, e_we, e_ir, e_dr, chk_bus;
    logic [31:0] e_ma, e_mw, e_ird, e_drd;
    e_en = 0; e_we = 0; e_ir = 0; e_dr = 0; chk_bus = 1;
    e_ma = '0; e_mw = '0; e_ird = '0; e_drd = '0;
    if (reset[k]) begin
      m_busy[k] = 0;
      m_blk[k]  = 1;
    end else if (!m_busy[k]) begin
      if (!m_blk[k] && (dm_req[k] || if_req[k])) begin
        e_en = 1;
        if (dm_req[k]) begin
          e_ma = dm_addr[k]; e_mw = dm_wdata[k]; e_we = dm_we[k]; m_dm[k] = 1;
        end else begin
          e_ma = if_addr[k]; e_mw = '0; e_we = 0; m_dm[k] = 0;
        end
        m_a[k] = e_ma; m_w[k] = e_mw; m_we[k] = e_we;
        m_busy[k] = 1;
        m_done_at[k] = cyc + lat_of(k);
      end else if (!m_blk[k]) begin
        chk_bus = 0;
      end
      m_blk[k] = 0;
    end else begin
      e_ma = m_a[k]; e_mw = m_w[k]; e_we = m_we[k];
      if (cyc == m_done_at[k]) begin
        if (m_dm[k]) begin
          e_dr  = 1;
          e_drd = m_we[k] ? 32'h0 : mem_rdata[k];
        end else if (if_req[k] && (if_addr[k] == m_a[k])) begin
          e_ir  = 1;
          e_ird = mem_rdata[k];
        end
        m_busy[k] = 0;
      end
    end
    chk($sformatf("d%0d mem_en", k),   mem_en[k],   e_en);
    chk($sformatf("d%0d if_ready", k), if_ready[k], e_ir);
    chk($sformatf("d%0d if_rdata", k), if_rdata[k], e_ird);
    chk($sformatf("d%0d dm_ready", k), dm_ready[k], e_dr);
    chk($sformatf("d%0d dm_rdata", k), dm_rdata[k], e_drd);
    chk($sformatf("d%0d stall_f", k),  stall_f[k],  if_req[k] & ~e_ir);
    chk($sformatf("d%0d stall_m", k),  stall_m[k],  dm_req[k] & ~e_dr);
    if (chk_bus) begin
      chk($sformatf("d%0d mem_we", k),    mem_we[k],    e_we);
      chk($sformatf("d%0d mem_addr", k),  mem_addr[k],  e_ma);
      chk($sformatf("d%0d mem_wdata", k), mem_wdata[k], e_mw);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic go();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) mem_rdata[k] = $urandom() | 32'h1000_0000;
  endtask

  task automatic clr(input int k);
    if_req[k] = 0; if_addr[k] = '0;
    dm_req[k] = 0; dm_we[k] = 0; dm_addr[k] = '0; dm_wdata[k] = '0;
  endtask

  // leaves the caller inside cycle 1, ready to drive its inputs
  task automatic start_scn();
    go();
    for (int k = 0; k < 2; k++) begin reset[k] = 1; clr(k); end
    go();
    for (int k = 0; k < 2; k++) reset[k] = 0;
    go();
  endtask

  task automatic new_dm(input int k);
    dm_req[k]   = 1;
    dm_we[k]    = $urandom_range(0, 1) == 1;
    dm_addr[k]  = 32'($urandom_range(0, 63)) << 2;
    dm_wdata[k] = $urandom();
  endtask

  task automatic rand_drive(input int k);
    reset[k] = ($urandom_range(0, 199) == 0);
    if (!dm_req[k]) begin
      if ($urandom_range(0, 3) == 0) new_dm(k);
    end else if (rdy_prev[k]) begin
      if ($urandom_range(0, 1) == 0) dm_req[k] = 0;
      else new_dm(k);
    end
    if ($urandom_range(0, 9) == 0) if_req[k] = ~if_req[k];
    if ($urandom_range(0, 7) == 0) if_addr[k] = 32'($urandom_range(0, 15)) << 2;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1; clr(k); mem_rdata[k] = '0;
    end

    // single fetch, MEM_LAT=2
    start_scn();
    if_req[0] = 1; if_addr[0] = 32'h40;
    @(negedge clk);
    chk("A c1 mem_en", mem_en[0], 1);
    chk("A c1 mem_addr", mem_addr[0], 32'h40);
    chk("A c1 stall_f", stall_f[0], 1);
    go(); @(negedge clk);
    chk("A c2 if_ready", if_ready[0], 0);
    chk("A c2 stall_f", stall_f[0], 1);
    go(); @(negedge clk);
    chk("A c3 if_ready", if_ready[0], 1);
    chk("A c3 if_rdata", if_rdata[0], mem_rdata[0]);
    chk("A c3 stall_f", stall_f[0], 0);
    go(); clr(0);

    // simultaneous fetch and DM read: DM first
    start_scn();
    if_req[0] = 1; if_addr[0] = 32'h40;
    dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h80;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) go();
      if (c == 4) dm_req[0] = 0;
      @(negedge clk);
      chk($sformatf("B c%0d stall_f", c), stall_f[0], c <= 5);
      if (c == 1) chk("B c1 mem_addr", mem_addr[0], 32'h80);
      if (c == 1 || c == 4) chk($sformatf("B c%0d mem_en", c), mem_en[0], 1);
      if (c == 3) begin
        chk("B c3 dm_ready", dm_ready[0], 1);
        chk("B c3 dm_rdata", dm_rdata[0], mem_rdata[0]);
      end
      if (c == 4) chk("B c4 mem_addr", mem_addr[0], 32'h40);
      if (c == 6) chk("B c6 if_ready", if_ready[0], 1);
    end
    go(); clr(0);

    // DM write held on the bus through completion
    start_scn();
    dm_req[0] = 1; dm_we[0] = 1; dm_addr[0] = 32'h80; dm_wdata[0] = 32'hDEADBEEF;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) go();
      @(negedge clk);
      chk($sformatf("C c%0d mem_en", c), mem_en[0], c == 1);
      chk($sformatf("C c%0d mem_we", c), mem_we[0], 1);
      chk($sformatf("C c%0d mem_addr", c), mem_addr[0], 32'h80);
      chk($sformatf("C c%0d mem_wdata", c), mem_wdata[0], 32'hDEADBEEF);
      chk($sformatf("C c%0d dm_ready", c), dm_ready[0], c == 3);
    end
    chk("C c3 dm_rdata", dm_rdata[0], 0);
    go(); clr(0);

    // fetch redirected mid-flight
    start_scn();
    if_req[0] = 1; if_addr[0] = 32'h40;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) go();
      if (c == 2) if_addr[0] = 32'h100;
      @(negedge clk);
      if (c == 3) begin
        chk("D c3 if_ready", if_ready[0], 0);
        chk("D c3 mem_en", mem_en[0], 0);
      end
      if (c == 4) begin
        chk("D c4 mem_en", mem_en[0], 1);
        chk("D c4 mem_addr", mem_addr[0], 32'h100);
      end
      if (c == 6) begin
        chk("D c6 if_ready", if_ready[0], 1);
        chk("D c6 if_rdata", if_rdata[0], mem_rdata[0]);
      end
    end
    go(); clr(0);

    // reset interrupting a DM read
    start_scn();
    dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h80;
    @(negedge clk);
    chk("E c1 mem_en", mem_en[0], 1);
    go(); reset[0] = 1; dm_req[0] = 0;
    @(negedge clk);
    chk("E c2 mem_en", mem_en[0], 0);
    chk("E c2 mem_addr", mem_addr[0], 0);
    chk("E c2 dm_ready", dm_ready[0], 0);
    go(); reset[0] = 0; if_req[0] = 1; if_addr[0] = 32'h40;
    @(negedge clk);
    chk("E c3 dm_ready", dm_ready[0], 0);
    chk("E c3 dm_rdata", dm_rdata[0], 0);
    chk("E c3 mem_en", mem_en[0], 0);
    chk("E c3 mem_addr", mem_addr[0], 0);
    go(); dm_req[0] = 1; dm_addr[0] = 32'h84;
    @(negedge clk);
    chk("E c4 mem_en", mem_en[0], 1);
    chk("E c4 mem_addr", mem_addr[0], 32'h84);
    go(); go();
    @(negedge clk);
    chk("E c6 dm_ready", dm_ready[0], 1);
    go(); clr(0);

    // MEM_LAT=1 back-to-back DM reads
    start_scn();
    dm_req[1] = 1; dm_we[1] = 0; dm_addr[1] = 32'hC0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) go();
      @(negedge clk);
      chk($sformatf("F c%0d mem_en", c), mem_en[1], (c % 2) == 1);
      chk($sformatf("F c%0d dm_ready", c), dm_ready[1], (c % 2) == 0);
    end
    go(); clr(1);

    // random traffic on both instances
    for (int n = 0; n < 4000; n++) begin
      go();
      for (int k = 0; k < 2; k++) rand_drive(k);
      @(negedge clk);
      for (int k = 0; k < 2; k++) rdy_prev[k] = dm_ready[k];
    end
    go();
    for (int k = 0; k < 2; k++) begin reset[k] = 0; clr(k); end
    repeat (10) go();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning cycles from mem_en to valid mem_rdata; legal range 1..7.
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have parameter DW, default 32, meaning data width.
REQ-004 SHALL have ports, in this order: clk  in  1  clock, rising edge only; reset  in  1  synchronous, active-high.
REQ-005 SHALL have ports for the fetch requester:
- if_req  in  1  fetch request
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetch data
- if_ready  out  1  fetch done pulse
REQ-006 SHALL have ports for the data-memory requester:
- dm_req  in  1  data request
- dm_we  in  1  write enable
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_rdata  out  DW  read data
- dm_ready  out  1  data done pulse
REQ-007 SHALL have ports to the single-ported unified memory:
- mem_en  out  1  access issue
- mem_we  out  1  write
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data
REQ-008 SHALL have ports: stall_f  out  1  fetch-stage stall; stall_m  out  1  memory-stage stall.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY_IF and BUSY_DM.
REQ-010 In IDLE with dm_req=1, SHALL grant DM (fixed priority DM over IF) and go to BUSY_DM; with only if_req=1, SHALL grant IF and go to BUSY_IF; with neither, SHALL stay in IDLE.
REQ-011 The grant cycle T SHALL be the issue cycle: mem_en=1 for exactly cycle T; mem_we=dm_we for a DM grant and 0 for an IF grant.
REQ-012 mem_addr, mem_wdata and mem_we SHALL be driven combinationally from the granted requester in cycle T, then from registers latched at T, held until completion.
REQ-013 A latency counter SHALL load MEM_LAT-1 at T, decrement each cycle, and define completion cycle C=T+MEM_LAT.
REQ-014 In cycle C, the FSM SHALL capture mem_rdata and return to IDLE; the earliest next issue is C+1, giving one access per MEM_LAT+1 cycles.
REQ-015 DM completion SHALL pulse dm_ready=1 in cycle C, with dm_rdata=mem_rdata (reads) or 0 (writes).
REQ-016 IF completion SHALL pulse if_ready=1 in cycle C with if_rdata=mem_rdata, only if if_req=1 and if_addr equals the latched address in C.
REQ-017 Otherwise (fetch redirected or withdrawn), the completion SHALL be discarded: no if_ready, state to IDLE, re-arbitration at C+1.
REQ-018 if_rdata and dm_rdata SHALL be 0 whenever their ready is 0.
REQ-019 The requester SHALL hold dm_req, dm_addr, dm_we and dm_wdata stable until dm_ready; DM accesses are never abandoned.
REQ-020 stall_f SHALL be if_req & ~if_ready, and stall_m SHALL be dm_req & ~dm_ready, both combinational.
REQ-021 A request arriving while the FSM is busy SHALL wait with no effect on the in-flight access, including a DM request during BUSY_IF.
REQ-022 Ready pulses SHALL last exactly one cycle; a requester holding req after ready SHALL be re-granted no earlier than C+1.

Reset
REQ-023 With reset=1 at a rising edge, the FSM SHALL enter IDLE, the counter 0, latched address/data/we 0.
REQ-024 While reset=1 and in the cycle following it, mem_en, if_ready, dm_ready, if_rdata, dm_rdata, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-025 An in-flight access interrupted by reset SHALL produce no ready pulse, and its late mem_rdata SHALL be ignored.

Structure
REQ-026 Package mem_arb_pkg SHALL hold the state enum type (IDLE, BUSY_IF, BUSY_DM) and default MEM_LAT constant.
REQ-027 The latency counter SHALL be a sub-module arb_lat_counter (load, decrement, done flag; width $clog2(MEM_LAT+1)).
REQ-028 All state SHALL be in synchronous-reset flops.

Verification (MEM_LAT=2, T=cycle 1)
REQ-029 Bench SHALL cover: if_req, if_addr=0x40 at cycle 1 -> mem_en cycle 1 addr 0x40; if_ready and if_rdata=mem_rdata cycle 3; stall_f=1 in cycles 1-2.
REQ-030 Bench SHALL cover: if_req and dm_req read 0x80 both at cycle 1 -> DM issue cycle 1, dm_ready cycle 3; IF issue cycle 4, if_ready cycle 6; stall_f=1 in cycles 1-5.
REQ-031 Bench SHALL cover: DM write 0x80/0xDEADBEEF at cycle 1 -> mem_en=mem_we=1 cycle 1; mem_addr/mem_wdata held through cycle 3; dm_ready cycle 3 with dm_rdata=0.
REQ-032 Bench SHALL cover: fetch 0x40 at cycle 1, if_addr changed to 0x100 at cycle 2 -> no if_ready cycle 3; reissue 0x100 cycle 4; if_ready cycle 6.
REQ-033 Bench SHALL cover: reset=1 in cycle 2 of a DM read -> no dm_ready in cycle 3; FSM IDLE; all outputs 0; a new request at cycle 4 is issued at cycle 4.
REQ-034 Bench SHALL cover: MEM_LAT=1 with back-to-back dm_req -> issues at cycles 1, 3, 5; dm_ready at cycles 2, 4, 6.
